// File: rtl/gate_bist_pkg.sv
// Shared constants, FSM state type and LFSR/MISR step functions for the gate BIST controller.
package gate_bist_pkg;

   localparam int unsigned PAT_W = 12;  // stimulus width (N1..N12)
   localparam int unsigned RSP_W = 10;  // response width (N98..N112)
   localparam int unsigned CNT_W = 17;  // one bit wider than pat_count so 65535 cannot wrap
   localparam int unsigned SET_W = 4;   // settle counter, covers SETTLE_CYC up to 15

   // x^12 + x^6 + x^4 + x + 1: feedback from bits 11, 5, 3, 0
   localparam logic [PAT_W-1:0] LFSR_TAPS = 12'h829;
   // x^10 + x^3 + 1: m[9] folds back into bits 0 and 3
   localparam logic [RSP_W-1:0] MISR_TAPS = 10'h009;

   localparam logic [PAT_W-1:0] DEFAULT_SEED = 12'hACE;

   typedef enum logic [1:0] {
      StIdle,
      StApply,
      StCapture,
      StDone
   } bist_state_e;

   // One shift of the stimulus LFSR; feedback enters at bit 0.
   function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] p);
      return {p[PAT_W-2:0], ^(p & LFSR_TAPS)};
   endfunction

   // One MISR compression step of response d into signature m.
   function automatic logic [RSP_W-1:0] misr_next(input logic [RSP_W-1:0] m,
                                                  input logic [RSP_W-1:0] d);
      logic [RSP_W-1:0] fb;
      fb = m[RSP_W-1] ? MISR_TAPS : '0;
      return {m[RSP_W-2:0], 1'b0} ^ fb ^ d;
   endfunction

endpackage

// File: rtl/gate_bist_misr.sv
// Multiple-input signature register compressing the gate model response.
module gate_bist_misr
   import gate_bist_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   input  logic [RSP_W-1:0] d,
   output logic [RSP_W-1:0] sig
);

   logic [RSP_W-1:0] sig_q, sig_d;

   // Next signature: clear wins over a compression step.
   always_comb begin
      sig_d = sig_q;
      if (clear) begin
         sig_d = '0;
      end else if (enable) begin
         sig_d = misr_next(sig_q, d);
      end
   end

   // Signature register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST controller: drives LFSR patterns into a 12-input gate model, holds each for
// SETTLE_CYC cycles, compresses the response into a MISR and compares the final signature.
module gate_bist_ctrl
   import gate_bist_pkg::*;
#(
   parameter int unsigned      SETTLE_CYC = 1,
   parameter logic [PAT_W-1:0] SEED       = DEFAULT_SEED
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [15:0]      pat_count,
   input  logic [RSP_W-1:0] exp_sig,
   output logic [PAT_W-1:0] dut_in,
   input  logic [RSP_W-1:0] dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [RSP_W-1:0] signature
);

   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

   bist_state_e      state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic [15:0]      npat_q, npat_d;
   logic [RSP_W-1:0] exp_q, exp_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             misr_clear;
   logic             misr_en;

   assign cnt_inc = cnt_q + CNT_W'(1);

   // Next-state and datapath control.
   always_comb begin
      state_d    = state_q;
      pat_d      = pat_q;
      cnt_d      = cnt_q;
      settle_d   = settle_q;
      npat_d     = npat_q;
      exp_d      = exp_q;
      misr_clear = 1'b0;
      misr_en    = 1'b0;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               pat_d      = SEED;
               cnt_d      = '0;
               settle_d   = '0;
               npat_d     = pat_count;
               exp_d      = exp_sig;
               misr_clear = 1'b1;
               state_d    = (pat_count == 16'd0) ? StDone : StApply;
            end
         end
         StApply: begin
            if (settle_q == SETTLE_LAST) begin
               settle_d = '0;
               state_d  = StCapture;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         StCapture: begin
            misr_en = 1'b1;
            pat_d   = lfsr_next(pat_q);
            cnt_d   = cnt_inc;
            // 17-bit compare: a count of 65535 terminates without wrapping.
            state_d = (cnt_inc == {1'b0, npat_q}) ? StDone : StApply;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Controller state, stimulus LFSR and latched run parameters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         pat_q    <= SEED;
         cnt_q    <= '0;
         settle_q <= '0;
         npat_q   <= '0;
         exp_q    <= '0;
      end else begin
         state_q  <= state_d;
         pat_q    <= pat_d;
         cnt_q    <= cnt_d;
         settle_q <= settle_d;
         npat_q   <= npat_d;
         exp_q    <= exp_d;
      end
   end

   gate_bist_misr u_misr (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (misr_clear),
      .enable (misr_en),
      .d      (dut_out),
      .sig    (signature)
   );

   // Status outputs decoded from the registered state.
   always_comb begin
      busy = (state_q == StApply) || (state_q == StCapture);
      done = (state_q == StDone);
      pass = done && (signature == exp_q);
   end

   assign dut_in = pat_q;

endmodule

// File: doc/gate_bist_ctrl.md
GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 1, range 1..15: cycles dut_in is held stable before each capture.
REQ-002 The block SHALL have parameter SEED, default 12'hACE: LFSR start pattern; 12'h000 is illegal.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a test run.
REQ-006 pat_count  input  16  number of patterns to apply, sampled with start.
REQ-007 exp_sig  input  10  expected final signature, sampled with start.
REQ-008 dut_in  output  12  stimulus to the 12-input gate model, bit0=N1 ... bit11=N12.
REQ-009 dut_out  input  10  gate model response; bit0..9 = N98,N104,N105,N106,N107,N108,N109,N110,N111,N112.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high from run completion until next accepted start.
REQ-012 pass  output  1  signature==exp_sig, valid only while done=1, else 0.
REQ-013 signature  output  10  current MISR contents.

Function
REQ-014 FSM states SHALL be IDLE, APPLY, CAPTURE, DONE.
REQ-015 start in IDLE or DONE SHALL load dut_in<=SEED, MISR<=0, pattern counter<=0, settle counter<=0, latch pat_count/exp_sig, clear done, and go to APPLY (or straight to DONE if pat_count==0).
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 APPLY SHALL hold dut_in constant for SETTLE_CYC cycles, then enter CAPTURE.
REQ-018 CAPTURE SHALL last exactly one cycle: MISR updates with dut_out, dut_in advances one LFSR step, pattern counter increments.
REQ-019 After the CAPTURE whose increment makes counter == pat_count, next state SHALL be DONE; otherwise APPLY.
REQ-020 done SHALL rise exactly N*(SETTLE_CYC+1) cycles after the edge that accepted start (N=pat_count); for N=0, one cycle after.
REQ-021 LFSR step SHALL be dut_in <= {dut_in[10:0], dut_in[11]^dut_in[5]^dut_in[3]^dut_in[0]}.
REQ-022 MISR step (x^10+x^3+1) SHALL be m'[0]=m[9]^d[0]; m'[3]=m[2]^m[9]^d[3]; m'[i]=m[i-1]^d[i] for other i.
REQ-023 pat_count 65535 SHALL run to completion without counter wrap (17-bit-safe compare or equivalent).
REQ-024 busy SHALL equal (state==APPLY or state==CAPTURE).
REQ-025 In DONE, dut_in and signature SHALL hold their final values until the next start.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, dut_in=SEED, MISR=0, counters=0, busy=0, done=0, pass=0, at any time including mid-run.
REQ-027 After reset release, the block SHALL not start a run without a new start pulse.

Structure
REQ-028 Package gate_bist_pkg SHALL hold PAT_W=12, RSP_W=10, LFSR/MISR tap constants, default SEED, and the FSM state enum.
REQ-029 The MISR SHALL be a sub-module gate_bist_misr (clk, rst_n, clear, enable, d[9:0], sig[9:0]); LFSR and FSM stay in gate_bist_ctrl.

Verification
REQ-030 Reset: assert rst_n=0 mid-run -> dut_in=12'hACE, signature=0, busy=done=pass=0 immediately; no activity after release without start.
REQ-031 Stimulus: start, pat_count=3, SETTLE_CYC=1 -> dut_in sequence 12'hACE, 12'h59C, 12'hB39, each held 2 cycles; done 6 cycles after start.
REQ-032 MISR: pat_count=2, dut_out tied 10'h3FF, exp_sig=10'h008 -> signature 10'h3FF after pattern 1, 10'h008 at done, pass=1; exp_sig=10'h009 -> pass=0.
REQ-033 Zero count: start, pat_count=0, exp_sig=0 -> done=1 next cycle, busy never high, signature=0, pass=1.
REQ-034 Busy start: second start during run with pat_count=5 -> ignored, run completes 5 patterns unchanged; start in DONE restarts from 12'hACE with done cleared.
REQ-035 Gate model hookup: full run against the 12-input gate model, pat_count=4095 -> signature matches reference-model MISR over same LFSR sequence.
